// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
// The FSM state type, byte geometry and read-port width live here.
package dmem_pkg;

  localparam int BYTE_W      = 8;
  localparam int DWORD_BYTES = 8;
  localparam int DWORD_W     = BYTE_W * DWORD_BYTES;
  localparam int RDATA_W     = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dmem_responder_byte_merge.sv
// Byte-masked merge of new write data over an existing doubleword.
// For each byte, the output takes the wdata byte if its wmask bit is set, else the old byte.
module byte_merge
  import dmem_pkg::*;
(
  input  logic [DWORD_W-1:0]     old_data,
  input  logic [DWORD_W-1:0]     wdata,
  input  logic [DWORD_BYTES-1:0] wmask,
  output logic [DWORD_W-1:0]     merged
);

  always_comb begin
    // NOTE: assigning a default before any conditional update keeps the block purely combinational (no inferred latch).
    merged = old_data;
    for (int i = 0; i < DWORD_BYTES; i++) begin
      if (wmask[i]) begin
        merged[i*BYTE_W +: BYTE_W] = wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked doubleword store with a registered 32-bit read port.
// After reset, a clear engine zeroes every location before ready is raised.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            addr,
  input  logic                   wr_en,
  input  logic [DWORD_W-1:0]     wdata,
  input  logic [DWORD_BYTES-1:0] wmask,
  output logic [RDATA_W-1:0]     rdata,
  output logic                   ready,
  output logic                   err
);

  localparam logic [IDX_W:0] CLR_LAST = (IDX_W + 1)'(DEPTH - 1);

  state_t               state_q, state_d;
  logic [IDX_W:0]       clr_cnt_q, clr_cnt_d;
  logic [RDATA_W-1:0]   rdata_q, rdata_d;
  logic                 err_q, err_d;

  logic [DWORD_W-1:0]   mem [DEPTH];
  logic                 mem_we;
  logic [IDX_W-1:0]     mem_waddr;
  logic [DWORD_W-1:0]   mem_wdata;

  logic [IDX_W-1:0]     idx;
  logic                 half;
  logic                 in_range;
  logic [31:0]          dw_addr;
  logic [DWORD_W-1:0]   rd_word;
  logic [DWORD_W-1:0]   merged;
  logic                 unused_addr_lsbs;

  // Byte offset within a word carries no meaning here: there is no misalignment trap.
  assign unused_addr_lsbs = ^addr[1:0];

  assign idx      = addr[IDX_W+2:3];
  assign half     = addr[2];
  assign dw_addr  = {3'b000, addr[31:3]};
  assign in_range = (dw_addr < 32'(DEPTH));
  assign rd_word  = mem[idx];

  byte_merge u_byte_merge (
    .old_data (rd_word),
    .wdata    (wdata),
    .wmask    (wmask),
    .merged   (merged)
  );

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = merged;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q[IDX_W-1:0];
        mem_wdata = '0;
        rdata_d   = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (wr_en) begin
          if (in_range) begin
            mem_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // rd_word is the pre-edge contents, so a same-edge write is seen one cycle later.
        if (in_range) begin
          rdata_d = half ? rd_word[63:32] : rd_word[31:0];
        end else begin
          rdata_d = '0;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // NOTE: the array has no reset branch so it maps onto RAM; the clear engine zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ready = (state_q == RUN);
  assign err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder at DEPTH=256.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_edges;

  dmem_responder #(.DEPTH(256)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wr_en (wr_en),
    .wdata (wdata),
    .wmask (wmask),
    .rdata (rdata),
    .ready (ready),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] expected, input string tag);
    addr  = a;
    wr_en = 1'b0;
    tick();
    check(tag, {32'h0, rdata}, {32'h0, expected});
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    addr  = a;
    wdata = d;
    wmask = m;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  // Counts edges until ready; optionally drives writes that the clear must ignore.
  task automatic wait_ready(input bit poke, output int n);
    n = 0;
    while (!ready && n < 1000) begin
      if (poke) begin
        addr  = (n < 128) ? 32'h0000_0800 : 32'h0000_0010;
        wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        wmask = 8'hFF;
        wr_en = 1'b1;
      end
      tick();
      n++;
      if (!ready) check("clear_rdata_zero", {32'h0, rdata}, 64'h0);
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    addr  = 32'h0;
    wr_en = 1'b0;
    wdata = 64'h0;
    wmask = 8'h0;
    repeat (3) tick();
    check("reset_rdata", {32'h0, rdata}, 64'h0);
    check("reset_ready", {63'h0, ready}, 64'h0);
    check("reset_err",   {63'h0, err},   64'h0);

    // Reset then clear, with writes attempted during the clear
    rst = 1'b0;
    wait_ready(1'b1, n_edges);
    check("clear_edges", 64'(n_edges), 64'd256);
    check("clear_err_untouched", {63'h0, err}, 64'h0);
    do_read(32'h0000_07F8, 32'h0, "read_last_after_clear");
    do_read(32'h0000_0010, 32'h0, "read_0x10_after_clear");

    // Full write and half select
    do_write(32'h0000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    do_read(32'h0000_0010, 32'h5566_7788, "full_lo");
    do_read(32'h0000_0014, 32'h1122_3344, "full_hi");

    // Masked write over the previous data
    do_write(32'h0000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    do_read(32'h0000_0010, 32'hAAAA_AAAA, "mask_lo");
    do_read(32'h0000_0014, 32'h1122_3344, "mask_hi");
    do_read(32'h0000_0013, 32'hAAAA_AAAA, "ignore_addr_lsbs");

    // Sparse mask at the last in-range doubleword
    do_write(32'h0000_07F8, 64'h0102_0304_0506_0708, 8'h81);
    do_read(32'h0000_07FC, 32'h0100_0000, "last_idx_hi");
    do_read(32'h0000_07F8, 32'h0000_0008, "last_idx_lo");

    // Read-before-write on the same index
    addr = 32'h0000_0010;
    tick();
    do_write(32'h0000_0010, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
    check("rbw_old", {32'h0, rdata}, 64'hAAAA_AAAA);
    tick();
    check("rbw_new", {32'h0, rdata}, 64'hCAFE_F00D);
    check("err_before_oor", {63'h0, err}, 64'h0);

    // wmask=0 write is a no-op
    do_write(32'h0000_0010, 64'h0, 8'h00);
    do_read(32'h0000_0014, 32'hDEAD_BEEF, "mask0_noop");
    check("mask0_no_err", {63'h0, err}, 64'h0);

    // Out of range: dropped, sticky err, reads return 0
    do_read(32'h0000_0800, 32'h0, "oor_read_no_err_data");
    check("oor_read_no_err", {63'h0, err}, 64'h0);
    do_write(32'h0000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    check("oor_write_err", {63'h0, err}, 64'h1);
    do_read(32'h0000_0000, 32'h0, "oor_no_alias_lo");
    do_read(32'h0000_0004, 32'h0, "oor_no_alias_hi");
    do_read(32'h0000_0800, 32'h0, "oor_read_zero");
    do_read(32'hFFFF_FFF0, 32'h0, "oor_read_high");
    do_write(32'h0000_0020, 64'h0000_0000_1234_5678, 8'hFF);
    check("err_sticky", {63'h0, err}, 64'h1);
    do_read(32'h0000_0020, 32'h1234_5678, "write_after_err");

    // Asynchronous reset from RUN, then reset again mid-clear
    #1 rst = 1'b1;
    #1;
    check("async_rst_rdata", {32'h0, rdata}, 64'h0);
    check("async_rst_ready", {63'h0, ready}, 64'h0);
    check("async_rst_err",   {63'h0, err},   64'h0);
    tick();
    rst = 1'b0;
    repeat (100) tick();
    check("mid_clear_not_ready", {63'h0, ready}, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(1'b0, n_edges);
    check("reclear_edges", 64'(n_edges), 64'd256);
    do_read(32'h0000_0010, 32'h0, "reclear_0x10");
    do_read(32'h0000_0020, 32'h0, "reclear_0x20");
    do_read(32'h0000_07F8, 32'h0, "reclear_last");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
